// File: rtl/h264frombytes_pkg.sv
// Shared constants, FSM states and the pending-stage commit record for the Annex-B byte unpacker.
package h264frombytes_pkg;

    localparam int BUFBITS_DEF = 40;
    localparam int WINBITS_DEF = 25;
    localparam int CNTW_DEF    = 6;

    localparam logic [7:0] ZERO_BYTE = 8'h00;
    localparam logic [7:0] EPB_BYTE  = 8'h03;
    localparam logic [7:0] SC_BYTE   = 8'h01;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    // dat is MSB-first: dat[15:8] is the older byte; unused low bits are zero
    typedef struct packed {
        logic [1:0]  cnt;
        logic [15:0] dat;
        logic        drop;
        logic        start;
    } commit_t;

endpackage

// File: rtl/h264frombytes_epb.sv
// Two-byte pending stage: start-code detection and emulation-prevention stripping.
// Latency: decisions are combinational on the accepted byte; pend/npend update on the next edge.
// Backpressure: none internally; the parent gates acc and drain_step on buffer room.
module h264frombytes_epb
    import h264frombytes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       acc,
    input  logic [7:0] byte_dat,
    input  logic       drain_step,
    output commit_t    cmt,
    output logic [1:0] npend
);

    logic [7:0] pend0, pend1;
    logic [7:0] pend0_nxt, pend1_nxt;
    logic [1:0] npend_q, npend_nxt;
    logic       zz;

    assign zz    = (npend_q == 2'd2) && (pend0 == ZERO_BYTE) && (pend1 == ZERO_BYTE);
    assign npend = npend_q;

    always_comb begin
        cmt       = '0;
        pend0_nxt = pend0;
        pend1_nxt = pend1;
        npend_nxt = npend_q;
        if (acc) begin
            if (zz && byte_dat == EPB_BYTE) begin
                cmt.cnt   = 2'd2;
                cmt.dat   = {pend0, pend1};
                cmt.drop  = 1'b1;
                npend_nxt = 2'd0;
            end else if (zz && byte_dat == SC_BYTE) begin
                cmt.start = 1'b1;
                npend_nxt = 2'd0;
            end else if (npend_q == 2'd2) begin
                // A third zero lands here too: the oldest zero is committed and later discarded by the clear
                cmt.cnt   = 2'd1;
                cmt.dat   = {pend0, ZERO_BYTE};
                pend0_nxt = pend1;
                pend1_nxt = byte_dat;
            end else if (npend_q == 2'd1) begin
                pend1_nxt = byte_dat;
                npend_nxt = 2'd2;
            end else begin
                pend0_nxt = byte_dat;
                npend_nxt = 2'd1;
            end
        end else if (drain_step && npend_q != 2'd0) begin
            cmt.cnt   = 2'd1;
            cmt.dat   = {pend0, ZERO_BYTE};
            pend0_nxt = pend1;
            npend_nxt = npend_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend0   <= '0;
            pend1   <= '0;
            npend_q <= '0;
        end else begin
            pend0   <= pend0_nxt;
            pend1   <= pend1_nxt;
            npend_q <= npend_nxt;
        end
    end

endmodule

// File: rtl/h264frombytes.sv
// Annex-B byte stream to MSB-aligned RBSP bit window with VL-bit shift consumption; optional EPB counter under H264FROMBYTES_EPBCOUNT_EN.
// Latency: a byte appears in BITS/AVAIL one cycle after it leaves the pending stage (two accepted bytes later, or during FLUSH drain).
// Backpressure: READY low while draining or when AVAIL > BUFBITS-16; drain pauses while fewer than 8 free bits remain.
module h264frombytes
    import h264frombytes_pkg::*;
#(
    parameter int BUFBITS = BUFBITS_DEF,
    parameter int WINBITS = WINBITS_DEF,
    parameter int CNTW    = CNTW_DEF
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               STROBE,
    input  logic [7:0]         BYTE,
    output logic               READY,
    input  logic               FLUSH,
    output logic               NALSTART,
    output logic [WINBITS-1:0] BITS,
    output logic [CNTW-1:0]    AVAIL,
    input  logic               SHIFT,
    input  logic [4:0]         VL
`ifdef H264FROMBYTES_EPBCOUNT_EN
    ,
    output logic [15:0]        EPBCOUNT
`endif
);

    localparam logic [CNTW-1:0] WIN_LIM = CNTW'(WINBITS);
    localparam logic [CNTW-1:0] ACC_LIM = CNTW'(BUFBITS - 16);
    localparam logic [CNTW-1:0] DRN_LIM = CNTW'(BUFBITS - 8);

    logic [BUFBITS-1:0] bitbuf, bitbuf_nxt, shifted, app;
    logic [CNTW-1:0]    avail_q, avail_nxt, avail_s, vl_ext, cbits;
    state_t             state, state_nxt;
    logic               live;
    logic               nal_q;
    logic               acc, drain_step, shift_ok;
    commit_t            cmt;
    logic [1:0]         npend;

    assign READY      = live && (state == IDLE) && (avail_q <= ACC_LIM);
    assign acc        = STROBE && READY;
    assign drain_step = (state == DRAIN) && (avail_q <= DRN_LIM);
    assign vl_ext     = CNTW'(VL);
    assign shift_ok   = SHIFT && (vl_ext <= avail_q) && (vl_ext <= WIN_LIM);

    assign BITS     = bitbuf[BUFBITS-1 -: WINBITS];
    assign AVAIL    = avail_q;
    assign NALSTART = nal_q;

    h264frombytes_epb u_epb (
        .clk        (CLK),
        .rst_n      (RESETN),
        .acc        (acc),
        .byte_dat   (BYTE),
        .drain_step (drain_step),
        .cmt        (cmt),
        .npend      (npend)
    );

    // Committed bytes land immediately after whatever survives this cycle's shift
    always_comb begin
        avail_s    = shift_ok ? (avail_q - vl_ext) : avail_q;
        shifted    = shift_ok ? (bitbuf << vl_ext) : bitbuf;
        app        = {cmt.dat, {(BUFBITS-16){1'b0}}} >> avail_s;
        cbits      = CNTW'({cmt.cnt, 3'b000});
        bitbuf_nxt = shifted | app;
        avail_nxt  = avail_s + cbits;
        if (cmt.start) begin
            bitbuf_nxt = '0;
            avail_nxt  = '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (FLUSH && (npend != 2'd0 || acc)) state_nxt = DRAIN;
            DRAIN:   if (npend == 2'd0 || (npend == 2'd1 && drain_step)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            bitbuf  <= '0;
            avail_q <= '0;
            state   <= IDLE;
            live    <= 1'b0;
            nal_q   <= 1'b0;
        end else begin
            bitbuf  <= bitbuf_nxt;
            avail_q <= avail_nxt;
            state   <= state_nxt;
            live    <= 1'b1;
            nal_q   <= cmt.start;
        end
    end

`ifdef H264FROMBYTES_EPBCOUNT_EN
    logic [15:0] epb_cnt;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            epb_cnt <= '0;
        end else if (cmt.start) begin
            epb_cnt <= '0;
        end else if (cmt.drop && epb_cnt != 16'hFFFF) begin
            epb_cnt <= epb_cnt + 16'd1;
        end
    end

    assign EPBCOUNT = epb_cnt;
`endif

    a_shift_legal: assert property (@(posedge CLK) disable iff (!RESETN) SHIFT |-> shift_ok);
    a_drop_pair:   assert property (@(posedge CLK) disable iff (!RESETN) cmt.drop |-> cmt.cnt == 2'd2);

endmodule

// File: tb/tb_h264frombytes.sv
// Self-checking bench for h264frombytes: directed scenarios plus a byte scoreboard drained through SHIFT.
module tb_h264frombytes;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       STROBE = 1'b0;
    logic [7:0] BYTE = 8'h00;
    logic       FLUSH = 1'b0;
    logic       SHIFT = 1'b0;
    logic [4:0] VL = 5'd0;
    wire        READY;
    wire        NALSTART;
    wire [24:0] BITS;
    wire [5:0]  AVAIL;
`ifdef H264FROMBYTES_EPBCOUNT_EN
    wire [15:0] EPBCOUNT;
`endif

    int         errors = 0;
    int         checks = 0;
    int         nal_cnt = 0;
    logic [7:0] sb[$];

    h264frombytes dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .STROBE   (STROBE),
        .BYTE     (BYTE),
        .READY    (READY),
        .FLUSH    (FLUSH),
        .NALSTART (NALSTART),
        .BITS     (BITS),
        .AVAIL    (AVAIL),
        .SHIFT    (SHIFT),
        .VL       (VL)
`ifdef H264FROMBYTES_EPBCOUNT_EN
        ,
        .EPBCOUNT (EPBCOUNT)
`endif
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (NALSTART === 1'b1) nal_cnt++;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        STROBE = 1'b1;
        BYTE   = b;
        while (READY !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (READY !== 1'b1) begin
            errors++;
            $display("FAIL send_ready byte=%h ready=%b required=1", b, READY);
        end
        tick();
        STROBE = 1'b0;
    endtask

    task automatic pulse_flush();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
    endtask

    task automatic clear_buf();
        int t;
        t = 0;
        while (AVAIL != 6'd0 && t < 20) begin
            SHIFT = 1'b1;
            VL    = (AVAIL > 6'd25) ? 5'd25 : AVAIL[4:0];
            tick();
            t++;
        end
        SHIFT = 1'b0;
        VL    = 5'd0;
    endtask

    task automatic consume(input int n, input string tag);
        int         got;
        int         t;
        logic [7:0] e;
        got = 0;
        t   = 0;
        while (got < n && t < 3000) begin
            if (AVAIL >= 6'd8) begin
                e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                checks++;
                if (BITS[24:17] !== e) begin
                    errors++;
                    $display("FAIL %s_byte%0d got=%h required=%h", tag, got, BITS[24:17], e);
                end
                SHIFT = 1'b1;
                VL    = 5'd8;
                got++;
            end else begin
                SHIFT = 1'b0;
                VL    = 5'd0;
            end
            tick();
            t++;
        end
        SHIFT = 1'b0;
        VL    = 5'd0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s_count got=%0d required=%0d", tag, got, n);
        end
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks += 4;
        if (AVAIL !== 6'd0) begin errors++; $display("FAIL reset_avail got=%0d required=0", AVAIL); end
        if (BITS !== 25'd0) begin errors++; $display("FAIL reset_bits got=%h required=0", BITS); end
        if (NALSTART !== 1'b0) begin errors++; $display("FAIL reset_nal got=%b required=0", NALSTART); end
        if (READY !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b required=0", READY); end
        RESETN = 1'b1;
        checks++;
        if (READY !== 1'b0) begin errors++; $display("FAIL release_ready_early got=%b required=0", READY); end
        tick();
        checks++;
        if (READY !== 1'b1) begin errors++; $display("FAIL release_ready got=%b required=1", READY); end
    endtask

    task automatic test_start_code();
        int n0;
        clear_buf();
        n0 = nal_cnt;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h25); send_byte(8'hB8);
        pulse_flush();
        repeat (4) tick();
        checks += 4;
        if (nal_cnt - n0 != 1) begin errors++; $display("FAIL sc_nal got=%0d required=1", nal_cnt - n0); end
        if (AVAIL !== 6'd16) begin errors++; $display("FAIL sc_avail got=%0d required=16", AVAIL); end
        if (BITS[24:9] !== 16'h25B8) begin errors++; $display("FAIL sc_bits got=%h required=25b8", BITS[24:9]); end
        if (BITS[8:0] !== 9'd0) begin errors++; $display("FAIL sc_tail got=%h required=0", BITS[8:0]); end
    endtask

    task automatic test_epb();
        int n0;
        clear_buf();
        n0 = nal_cnt;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h03); send_byte(8'h01);
        pulse_flush();
        repeat (4) tick();
        checks += 3;
        if (nal_cnt - n0 != 1) begin errors++; $display("FAIL epb_nal got=%0d required=1", nal_cnt - n0); end
        if (AVAIL !== 6'd24) begin errors++; $display("FAIL epb_avail got=%0d required=24", AVAIL); end
        if (BITS !== {24'h000001, 1'b0}) begin errors++; $display("FAIL epb_bits got=%h required=%h", BITS, {24'h000001, 1'b0}); end
`ifdef H264FROMBYTES_EPBCOUNT_EN
        checks++;
        if (EPBCOUNT !== 16'd1) begin errors++; $display("FAIL epb_count got=%0d required=1", EPBCOUNT); end
`endif
    endtask

    task automatic test_four_zero();
        int n0;
        clear_buf();
        n0 = nal_cnt;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA);
        pulse_flush();
        repeat (4) tick();
        checks += 3;
        if (nal_cnt - n0 != 1) begin errors++; $display("FAIL z4_nal got=%0d required=1", nal_cnt - n0); end
        if (AVAIL !== 6'd8) begin errors++; $display("FAIL z4_avail got=%0d required=8", AVAIL); end
        if (BITS !== {8'hAA, 17'd0}) begin errors++; $display("FAIL z4_bits got=%h required=%h", BITS, {8'hAA, 17'd0}); end
    endtask

    task automatic test_fill_backpressure();
        logic [7:0] b;
        clear_buf();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        for (int i = 1; i <= 6; i++) begin
            b = 8'(i * 8'h11);
            sb.push_back(b);
            send_byte(b);
        end
        checks += 3;
        if (AVAIL !== 6'd32) begin errors++; $display("FAIL fill_avail got=%0d required=32", AVAIL); end
        if (READY !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b required=0", READY); end
        if (BITS[24:5] !== {sb[0], sb[1], sb[2][7:4]}) begin
            errors++; $display("FAIL fill_bits got=%h required=%h", BITS[24:5], {sb[0], sb[1], sb[2][7:4]});
        end
        SHIFT = 1'b1; VL = 5'd20;
        tick();
        SHIFT = 1'b0; VL = 5'd0;
        checks += 3;
        if (READY !== 1'b1) begin errors++; $display("FAIL fill_recover got=%b required=1", READY); end
        if (AVAIL !== 6'd12) begin errors++; $display("FAIL fill_avail12 got=%0d required=12", AVAIL); end
        if (BITS[24:13] !== {sb[2][3:0], sb[3]}) begin
            errors++; $display("FAIL fill_rem got=%h required=%h", BITS[24:13], {sb[2][3:0], sb[3]});
        end
        SHIFT = 1'b1; VL = 5'd4;
        tick();
        SHIFT = 1'b0; VL = 5'd0;
        repeat (3) void'(sb.pop_front());
        sb.push_back(8'h77); send_byte(8'h77);
        sb.push_back(8'h88); send_byte(8'h88);
        pulse_flush();
        consume(5, "fill");
        checks++;
        if (AVAIL !== 6'd0) begin errors++; $display("FAIL fill_empty got=%0d required=0", AVAIL); end
    endtask

    task automatic test_shift_with_commit();
        logic [15:0] old;
        logic [24:0] exp;
        clear_buf();
        old = 16'hC35A;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(old[15:8]); send_byte(old[7:0]); send_byte(8'h7E); send_byte(8'h99);
        checks++;
        if (AVAIL !== 6'd16) begin errors++; $display("FAIL swc_pre got=%0d required=16", AVAIL); end
        STROBE = 1'b1; BYTE = 8'hE1; SHIFT = 1'b1; VL = 5'd5;
        tick();
        STROBE = 1'b0; SHIFT = 1'b0; VL = 5'd0;
        exp = {old[10:0], 8'h7E, 6'd0};
        checks += 2;
        if (AVAIL !== 6'd19) begin errors++; $display("FAIL swc_avail got=%0d required=19", AVAIL); end
        if (BITS !== exp) begin errors++; $display("FAIL swc_bits got=%h required=%h", BITS, exp); end
    endtask

    task automatic test_reset_mid_drain();
        pulse_flush();
        checks++;
        if (READY !== 1'b0) begin errors++; $display("FAIL drain_ready got=%b required=0", READY); end
        RESETN = 1'b0;
        #1;
        checks += 4;
        if (AVAIL !== 6'd0) begin errors++; $display("FAIL mrst_avail got=%0d required=0", AVAIL); end
        if (READY !== 1'b0) begin errors++; $display("FAIL mrst_ready got=%b required=0", READY); end
        if (NALSTART !== 1'b0) begin errors++; $display("FAIL mrst_nal got=%b required=0", NALSTART); end
        if (BITS !== 25'd0) begin errors++; $display("FAIL mrst_bits got=%h required=0", BITS); end
        tick();
        RESETN = 1'b1;
        repeat (3) tick();
        pulse_flush();
        repeat (4) tick();
        checks += 2;
        if (AVAIL !== 6'd0) begin errors++; $display("FAIL mrst_discard got=%0d required=0", AVAIL); end
        if (READY !== 1'b1) begin errors++; $display("FAIL mrst_ready_after got=%b required=1", READY); end
    endtask

    task automatic test_back_to_back();
        clear_buf();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        fork
            begin
                logic [7:0] b;
                logic [7:0] prev;
                prev = 8'hFF;
                for (int i = 0; i < 40; i++) begin
                    b = 8'($urandom_range(0, 255));
                    if (prev == 8'h00 && b == 8'h00) b = 8'h5C;
                    sb.push_back(b);
                    send_byte(b);
                    prev = b;
                end
                pulse_flush();
            end
            consume(40, "b2b");
        join
        checks++;
        if (AVAIL !== 6'd0) begin errors++; $display("FAIL b2b_empty got=%0d required=0", AVAIL); end
    endtask

    initial begin
        test_reset();
        test_start_code();
        test_epb();
        test_four_zero();
        test_fill_backpressure();
        test_shift_with_commit();
        test_reset_mid_drain();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
